// File: rtl/ex_mem_dual.sv
// Dual-lane EX/MEM register that holds the pipeline while multiplies finish, then commits both lanes together.
// Optional stall-cycle performance counter is built when EXMEM_PERF_EN is defined.
module ex_mem_dual #(
  parameter int MAXWAIT = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] solutione,
  input  logic [31:0] solutione2,
  input  logic [31:0] writedatae,
  input  logic [31:0] writedatae2,
  input  logic [4:0]  writerege,
  input  logic [4:0]  writerege2,
  input  logic        regwritee,
  input  logic        regwritee2,
  input  logic        memtorege,
  input  logic        memtorege2,
  input  logic        memwritee,
  input  logic        memwritee2,
  input  logic        multsele,
  input  logic        multsele2,
  input  logic        multready,
  input  logic        multready2,
  input  logic        flushe,
  output logic [31:0] aluoutm,
  output logic [31:0] aluoutm2,
  output logic [31:0] writedatam,
  output logic [31:0] writedatam2,
  output logic [4:0]  writeregm,
  output logic [4:0]  writeregm2,
  output logic        regwritem,
  output logic        regwritem2,
  output logic        memtoregm,
  output logic        memtoregm2,
  output logic        memwritem,
  output logic        memwritem2,
  output logic        stallmul,
  output logic        mulerr,
  output logic [31:0] stallcount
);
  localparam int CW = (MAXWAIT > 1) ? $clog2(MAXWAIT) : 1;

  typedef struct packed {
    logic [31:0] sol;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic        rw;
    logic        mtr;
    logic        mw;
  } lane_t;

  typedef enum logic {IDLE, MULWAIT} state_t;

  state_t        state, state_nxt;
  lane_t         e1, e2, m1, m2, m1_nxt, m2_nxt;
  lane_t         hold1, hold2, hold1_nxt, hold2_nxt;
  logic          done1, done2, done1_nxt, done2_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          mulerr_nxt, stall_raw;
  logic          pend1, pend2, all_done, timeout;

  assign e1 = {solutione, writedatae, writerege, regwritee, memtorege, memwritee};
  assign e2 = {solutione2, writedatae2, writerege2, regwritee2, memtorege2, memwritee2};

  assign pend1    = multsele & ~multready;
  assign pend2    = multsele2 & ~multready2;
  assign all_done = (done1 | multready) & (done2 | multready2);
  assign timeout  = (cnt == CW'(MAXWAIT - 1));

  always_comb begin
    state_nxt  = state;
    hold1_nxt  = hold1;
    hold2_nxt  = hold2;
    done1_nxt  = done1;
    done2_nxt  = done2;
    cnt_nxt    = cnt;
    mulerr_nxt = mulerr;
    m1_nxt     = '0;
    m2_nxt     = '0;
    stall_raw  = 1'b0;
    case (state)
      IDLE: begin
        if (flushe) begin
          state_nxt = IDLE;
        end else if (pend1 || pend2) begin
          // Non-pending solutions are captured now; forwarding changes under the bubbles.
          stall_raw = 1'b1;
          state_nxt = MULWAIT;
          hold1_nxt = e1;
          hold2_nxt = e2;
          if (pend1) hold1_nxt.sol = '0;
          if (pend2) hold2_nxt.sol = '0;
          done1_nxt = ~pend1;
          done2_nxt = ~pend2;
          cnt_nxt   = '0;
        end else begin
          m1_nxt = e1;
          m2_nxt = e2;
        end
      end
      MULWAIT: begin
        if (flushe) begin
          state_nxt = IDLE;
          done1_nxt = 1'b0;
          done2_nxt = 1'b0;
        end else begin
          if (!done1 && multready) begin
            hold1_nxt.sol = solutione;
            done1_nxt     = 1'b1;
          end
          if (!done2 && multready2) begin
            hold2_nxt.sol = solutione2;
            done2_nxt     = 1'b1;
          end
          if (all_done || timeout) begin
            m1_nxt     = hold1;
            m2_nxt     = hold2;
            m1_nxt.sol = done1 ? hold1.sol : (multready ? solutione : '0);
            m2_nxt.sol = done2 ? hold2.sol : (multready2 ? solutione2 : '0);
            state_nxt  = IDLE;
            done1_nxt  = 1'b0;
            done2_nxt  = 1'b0;
            if (!all_done) mulerr_nxt = 1'b1;
          end else begin
            stall_raw = 1'b1;
            cnt_nxt   = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stallmul = stall_raw & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      m1     <= '0;
      m2     <= '0;
      hold1  <= '0;
      hold2  <= '0;
      done1  <= 1'b0;
      done2  <= 1'b0;
      cnt    <= '0;
      mulerr <= 1'b0;
    end else begin
      state  <= state_nxt;
      m1     <= m1_nxt;
      m2     <= m2_nxt;
      hold1  <= hold1_nxt;
      hold2  <= hold2_nxt;
      done1  <= done1_nxt;
      done2  <= done2_nxt;
      cnt    <= cnt_nxt;
      mulerr <= mulerr_nxt;
    end
  end

  assign aluoutm     = m1.sol;
  assign aluoutm2    = m2.sol;
  assign writedatam  = m1.wd;
  assign writedatam2 = m2.wd;
  assign writeregm   = m1.wr;
  assign writeregm2  = m2.wr;
  assign regwritem   = m1.rw;
  assign regwritem2  = m2.rw;
  assign memtoregm   = m1.mtr;
  assign memtoregm2  = m2.mtr;
  assign memwritem   = m1.mw;
  assign memwritem2  = m2.mw;

`ifdef EXMEM_PERF_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         perf_cnt <= '0;
    else if (stallmul) perf_cnt <= perf_cnt + 32'd1;
  end

  assign stallcount = perf_cnt;
`else
  assign stallcount = '0;
`endif

endmodule

// File: tb/tb_ex_mem_dual.sv
// Bench for ex_mem_dual: directed scenarios plus random lane-pair transactions against a transaction-level model.
module tb_ex_mem_dual;
  localparam int MW = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] solutione, solutione2, writedatae, writedatae2;
  logic [4:0]  writerege, writerege2;
  logic        regwritee, regwritee2, memtorege, memtorege2, memwritee, memwritee2;
  logic        multsele, multsele2, multready, multready2, flushe;
  logic [31:0] aluoutm, aluoutm2, writedatam, writedatam2;
  logic [4:0]  writeregm, writeregm2;
  logic        regwritem, regwritem2, memtoregm, memtoregm2, memwritem, memwritem2;
  logic        stallmul, mulerr;
  logic [31:0] stallcount;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        mulerr_exp = 1'b0;
  logic [31:0] perf_exp = '0;

  ex_mem_dual #(.MAXWAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .solutione(solutione), .solutione2(solutione2),
    .writedatae(writedatae), .writedatae2(writedatae2),
    .writerege(writerege), .writerege2(writerege2),
    .regwritee(regwritee), .regwritee2(regwritee2),
    .memtorege(memtorege), .memtorege2(memtorege2),
    .memwritee(memwritee), .memwritee2(memwritee2),
    .multsele(multsele), .multsele2(multsele2),
    .multready(multready), .multready2(multready2),
    .flushe(flushe),
    .aluoutm(aluoutm), .aluoutm2(aluoutm2),
    .writedatam(writedatam), .writedatam2(writedatam2),
    .writeregm(writeregm), .writeregm2(writeregm2),
    .regwritem(regwritem), .regwritem2(regwritem2),
    .memtoregm(memtoregm), .memtoregm2(memtoregm2),
    .memwritem(memwritem), .memwritem2(memwritem2),
    .stallmul(stallmul), .mulerr(mulerr), .stallcount(stallcount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bubble(input string tag);
    chk(tag, 32'({regwritem, memtoregm, memwritem, regwritem2, memtoregm2, memwritem2}), 32'd0);
  endtask

  task automatic chk_perf();
`ifdef EXMEM_PERF_EN
    chk("stallcount", stallcount, perf_exp);
`else
    chk("stallcount", stallcount, 32'd0);
`endif
  endtask

  task automatic rand_e();
    solutione  = $urandom;  solutione2  = $urandom;
    writedatae = $urandom;  writedatae2 = $urandom;
    writerege  = 5'($urandom); writerege2 = 5'($urandom);
    {regwritee, memtorege, memwritee}    = 3'($urandom);
    {regwritee2, memtorege2, memwritee2} = 3'($urandom);
  endtask

  // One instruction pair from issue to commit. d = cycles after issue that multready arrives.
  task automatic run_pair(input bit ms1, input int d1, input logic [31:0] v1,
                          input bit ms2, input int d2, input logic [31:0] v2);
    logic [31:0] wd1, wd2, x1, x2;
    logic [7:0]  c1, c2;
    int          need, t;
    bit          to;
    wd1 = $urandom; wd2 = $urandom;
    c1 = 8'($urandom); c2 = 8'($urandom);
    need = 0;
    if (ms1 && d1 > need) need = d1;
    if (ms2 && d2 > need) need = d2;
    to = (need > MW);
    t  = to ? MW : need;
    x1 = (!ms1 || d1 <= MW) ? v1 : 32'd0;
    x2 = (!ms2 || d2 <= MW) ? v2 : 32'd0;
    for (int c = 0; c <= t; c++) begin
      rand_e();
      flushe     = 1'b0;
      multsele   = ms1;
      multsele2  = ms2;
      multready  = ms1 ? (c == d1) : 1'($urandom);
      multready2 = ms2 ? (c == d2) : 1'($urandom);
      if (c == 0) begin
        writedatae = wd1; writedatae2 = wd2;
        {writerege, regwritee, memtorege, memwritee}     = c1;
        {writerege2, regwritee2, memtorege2, memwritee2} = c2;
        if (!ms1) solutione  = v1;
        if (!ms2) solutione2 = v2;
      end
      if (ms1 && c == d1) solutione  = v1;
      if (ms2 && c == d2) solutione2 = v2;
      @(negedge clk);
      chk("stallmul", 32'(stallmul), 32'(c < t));
      if (c < t) perf_exp++;
      @(posedge clk); #1;
      if (c < t) chk_bubble("bubble");
    end
    if (to) mulerr_exp = 1'b1;
    chk("aluoutm", aluoutm, x1);
    chk("aluoutm2", aluoutm2, x2);
    chk("writedatam", writedatam, wd1);
    chk("writedatam2", writedatam2, wd2);
    chk("ctrl1", 32'({writeregm, regwritem, memtoregm, memwritem}), 32'(c1));
    chk("ctrl2", 32'({writeregm2, regwritem2, memtoregm2, memwritem2}), 32'(c2));
    chk("mulerr", 32'(mulerr), 32'(mulerr_exp));
    chk_perf();
  endtask

  initial begin
    reset = 1'b1;
    rand_e();
    flushe = 1'b0; multsele = 1'b1; multsele2 = 1'b0; multready = 1'b0; multready2 = 1'b0;
    #2;
    chk("rst_stallmul", 32'(stallmul), 32'd0);
    chk("rst_aluoutm", aluoutm, 32'd0);
    chk("rst_ctrl", 32'({writeregm, regwritem, writeregm2, regwritem2}), 32'd0);
    chk("rst_mulerr", 32'(mulerr), 32'd0);
    chk("rst_stallcount", stallcount, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Plain ALU pair, then the directed multiply scenarios.
    run_pair(1'b0, 0, 32'h12, 1'b0, 0, 32'h34);
    run_pair(1'b1, 3, 32'h00C8, 1'b0, 0, 32'h7);
    run_pair(1'b1, 5, 32'h99, 1'b1, 2, 32'h55);
    run_pair(1'b1, 0, 32'hAB, 1'b1, 0, 32'hCD);

    // Flush in IDLE with a pending multiply: bubble, no stall.
    rand_e();
    multsele = 1'b1; multready = 1'b0; multsele2 = 1'b0; flushe = 1'b1; regwritee = 1'b1;
    @(negedge clk);
    chk("idleflush_stall", 32'(stallmul), 32'd0);
    @(posedge clk); #1;
    chk_bubble("idleflush_bubble");

    // Flush in the second MULWAIT cycle, then a stray ready pulse.
    rand_e();
    flushe = 1'b0; multsele = 1'b1; multready = 1'b0; regwritee = 1'b1;
    @(negedge clk);
    chk("mflush_stall0", 32'(stallmul), 32'd1);
    @(posedge clk); #1;
    rand_e();
    @(negedge clk);
    chk("mflush_stall1", 32'(stallmul), 32'd1);
    @(posedge clk); #1;
    rand_e();
    flushe = 1'b1;
    @(negedge clk);
    chk("mflush_stall2", 32'(stallmul), 32'd0);
    perf_exp += 2;
    @(posedge clk); #1;
    chk_bubble("mflush_bubble");
    rand_e();
    flushe = 1'b0; multsele = 1'b0; multsele2 = 1'b0; multready = 1'b1; multready2 = 1'b1;
    solutione = 32'hABC; writerege = 5'd3; {regwritee, memtorege, memwritee} = 3'b000;
    @(negedge clk);
    chk("late_ready_stall", 32'(stallmul), 32'd0);
    @(posedge clk); #1;
    chk("late_ready_alu", aluoutm, 32'hABC);
    chk("late_ready_ctrl", 32'({writeregm, regwritem}), 32'({5'd3, 1'b0}));

    // Timeout: lane1 never ready.
    run_pair(1'b1, 1000, 32'hDEAD, 1'b0, 0, 32'h11);
    chk("mulerr_sticky", 32'(mulerr), 32'd1);

    for (int i = 0; i < 40; i++)
      run_pair(1'($urandom), int'($urandom_range(0, MW + 2)), $urandom,
               1'($urandom), int'($urandom_range(0, MW + 2)), $urandom);

    // Reset in the middle of a multiply wait.
    rand_e();
    flushe = 1'b0; multsele = 1'b1; multready = 1'b0; multsele2 = 1'b0;
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    chk("midrst_stallmul", 32'(stallmul), 32'd0);
    chk("midrst_mulerr", 32'(mulerr), 32'd0);
    chk("midrst_stallcount", stallcount, 32'd0);
    chk("midrst_aluoutm", aluoutm, 32'd0);
    mulerr_exp = 1'b0;
    perf_exp   = '0;
    @(negedge clk);
    reset = 1'b0;
    run_pair(1'b0, 0, $urandom, 1'b0, 0, $urandom);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
